// File: rtl/pipe_pkg.sv
// Shared definitions for the core's inter-stage pipeline buffers.
// Default field widths and the register-writeback bundle layout.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int DEF_PC_W    = 32;
    localparam int DEF_INSTR_W = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 5;

    typedef struct packed {
        logic                  we;
        logic [DEF_ADDR_W-1:0] waddr;
        logic [DEF_DATA_W-1:0] wdata;
    } wb_bundle_t;

endpackage

// File: rtl/pipe_slot.sv
// One buffer entry: a valid bit plus a payload register.
// Clear (reset or flush) zeroes the payload; drop only invalidates it.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic         i_drop,
    input  logic [W-1:0] i_d,
    output logic         o_v,
    output logic [W-1:0] o_d
);

    logic         r_v;
    logic [W-1:0] r_d;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_v <= 1'b0;
            r_d <= '0;
        end else if (i_load) begin
            r_v <= 1'b1;
            r_d <= i_d;
        end else if (i_drop) begin
            r_v <= 1'b0;
        end
    end

    assign o_v = r_v;
    assign o_d = r_d;

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline buffer between core stages with flush, optional skid
// entry (registered in_ready) and a saturating stall counter.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter bit SKID    = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic               in_we,
    input  logic [ADDR_W-1:0]  in_waddr,
    input  logic [DATA_W-1:0]  in_wdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic               out_we,
    output logic [ADDR_W-1:0]  out_waddr,
    output logic [DATA_W-1:0]  out_wdata,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam int PW = INSTR_W + PC_W + 1 + ADDR_W + DATA_W;

    logic          w_m_v, w_s_v, w_acc, w_pop, w_in_ready;
    logic          w_m_load, w_m_drop, w_m_we;
    logic [PW-1:0] w_in_d, w_m_d, w_s_d, w_m_nxt;
    logic [CNT_W-1:0] r_stall;

    assign w_in_d = {in_instr, in_pc, in_we, in_waddr, in_wdata};
    assign w_acc  = in_valid & w_in_ready;
    assign w_pop  = w_m_v & out_ready;

    // M refills from S when S holds the next entry, otherwise from the input.
    assign w_m_load = (w_acc & (~w_m_v | w_pop)) | (w_pop & w_s_v);
    assign w_m_drop = w_pop & ~w_s_v & ~w_acc;
    assign w_m_nxt  = w_s_v ? w_s_d : w_in_d;

    pipe_slot #(.W(PW)) u_m (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (flush),
        .i_load (w_m_load),
        .i_drop (w_m_drop),
        .i_d    (w_m_nxt),
        .o_v    (w_m_v),
        .o_d    (w_m_d)
    );

    generate
        if (SKID) begin : g_skid
            // Accepts only while M is stalled; S.v alone gates in_ready.
            pipe_slot #(.W(PW)) u_s (
                .clk    (clk),
                .reset  (reset),
                .i_clr  (flush),
                .i_load (w_m_v & ~w_pop & w_acc),
                .i_drop (w_pop),
                .i_d    (w_in_d),
                .o_v    (w_s_v),
                .o_d    (w_s_d)
            );
            assign w_in_ready = ~w_s_v;
        end else begin : g_noskid
            assign w_s_v      = 1'b0;
            assign w_s_d      = '0;
            assign w_in_ready = ~w_m_v | out_ready;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall <= '0;
        end else if (!flush && w_m_v && !out_ready && (r_stall != {CNT_W{1'b1}})) begin
            r_stall <= r_stall + 1'b1;
        end
    end

    assign {out_instr, out_pc, w_m_we, out_waddr, out_wdata} = w_m_d;
    assign out_we    = w_m_we & w_m_v;
    assign out_valid = w_m_v;
    assign in_ready  = w_in_ready;
    assign stall_cnt = r_stall;

endmodule
